// File: rtl/adc_sdram_pkg.sv
// Shared types and defaults for the ADC-to-SDRAM capture path.
package adc_sdram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer; the head word is visible on dout whenever not empty.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full  = count[AW];
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adc_capture_writer.sv
// Buffers ADC samples and writes them one word at a time to consecutive SDRAM addresses.
//   state       | meaning
//   ST_IDLE     | waiting for Arm; Done/Overflow hold their last values
//   ST_CAPTURE  | accepting samples; launches a write when FIFO has data and the bus is free
//   ST_ISSUE    | first cycle of a write request
//   ST_WAIT_ACK | request held stable until Ack
//   ST_DRAIN    | aborted: discard buffered samples
//   ST_DONE     | all words written; Done raised
module adc_capture_writer
  import adc_sdram_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int FIFO_AW = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] SampleData,
  input  logic              SampleValid,
  input  logic              Arm,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] CaptureLen,
  output logic              Req,
  output logic              WnR,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataOut,
  input  logic              Busy,
  input  logic              Ack,
  output logic              Capturing,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W-1:0] WordsWritten
);

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] cap_len;
  logic [ADDR_W-1:0] accepted;
  logic [ADDR_W-1:0] words_next;
  logic              abort_pend;
  logic              in_write;
  logic              sample_ok;
  logic              push;
  logic              pop;
  logic              drop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign WnR        = 1'b1;
  assign in_write   = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
  assign sample_ok  = SampleValid && Capturing && !abort_pend && (accepted != cap_len);
  assign pop        = in_write && Ack;
  assign push       = sample_ok && (!fifo_full || pop);
  assign drop       = sample_ok && fifo_full && !pop;
  assign flush      = ((state == ST_IDLE) && Arm) || (state == ST_DRAIN);
  assign words_next = WordsWritten + ADDR_W'(1);

  sample_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (SampleData),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      base_addr    <= '0;
      cap_len      <= '0;
      accepted     <= '0;
      abort_pend   <= 1'b0;
      Req          <= 1'b0;
      Address      <= '0;
      DataOut      <= '0;
      Capturing    <= 1'b0;
      Done         <= 1'b0;
      Overflow     <= 1'b0;
      WordsWritten <= '0;
    end else begin
      if (push) accepted <= accepted + ADDR_W'(1);
      if (drop) Overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (Arm) begin
            base_addr    <= BaseAddr;
            cap_len      <= CaptureLen;
            accepted     <= '0;
            abort_pend   <= 1'b0;
            Overflow     <= 1'b0;
            WordsWritten <= '0;
            if (CaptureLen == '0) begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end else begin
              state     <= ST_CAPTURE;
              Capturing <= 1'b1;
              Done      <= 1'b0;
            end
          end
        end
        ST_CAPTURE: begin
          if (Abort) begin
            state     <= ST_DRAIN;
            Capturing <= 1'b0;
          end else if (!fifo_empty && !Busy && !Ack) begin
            Req     <= 1'b1;
            Address <= base_addr + WordsWritten;
            DataOut <= fifo_head;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT_ACK: begin
          if (Abort) abort_pend <= 1'b1;
          // An abort only takes effect once the outstanding write has been acknowledged.
          if (Ack) begin
            Req          <= 1'b0;
            WordsWritten <= words_next;
            if (Abort || abort_pend) begin
              state     <= ST_DRAIN;
              Capturing <= 1'b0;
            end else if (words_next == cap_len) begin
              state     <= ST_DONE;
              Capturing <= 1'b0;
              Done      <= 1'b1;
            end else begin
              state <= ST_CAPTURE;
            end
          end else begin
            state <= ST_WAIT_ACK;
          end
        end
        ST_DRAIN: begin
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_writer.sv
// Self-checking bench: SDRAM responder records every write; tests compare against expected word lists.
module tb_adc_capture_writer;

  logic        Clk, Reset_n, SampleValid, Arm, Abort, Busy, Ack;
  logic [15:0] SampleData, DataOut;
  logic [21:0] BaseAddr, CaptureLen, Address, WordsWritten;
  logic        Req, WnR, Capturing, Done, Overflow;

  int checks = 0;
  int errors = 0;
  int ack_dly = 1;
  int ack_hold = 1;
  int hold_err = 0;
  int req_busy = 0;
  logic [21:0] got_addr[$];
  logic [15:0] got_data[$];

  localparam logic [63:0] RST_VEC = {1'b0, 1'b1, 22'h0, 16'h0, 1'b0, 1'b0, 1'b0, 22'h0};

  adc_capture_writer #(.DATA_W(16), .ADDR_W(22), .FIFO_AW(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SampleData(SampleData), .SampleValid(SampleValid),
    .Arm(Arm), .Abort(Abort), .BaseAddr(BaseAddr), .CaptureLen(CaptureLen),
    .Req(Req), .WnR(WnR), .Address(Address), .DataOut(DataOut), .Busy(Busy), .Ack(Ack),
    .Capturing(Capturing), .Done(Done), .Overflow(Overflow), .WordsWritten(WordsWritten)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // SDRAM model: log each new request, ack after ack_dly cycles, hold Ack for ack_hold cycles.
  initial begin
    Ack = 1'b0;
    forever begin
      @(negedge Clk);
      if (Req === 1'b1) begin
        logic [21:0] a;
        logic [15:0] d;
        int k;
        a = Address;
        d = DataOut;
        got_addr.push_back(a);
        got_data.push_back(d);
        k = 0;
        while (Req === 1'b1 && k < ack_dly) begin
          @(negedge Clk);
          k++;
          if (Req === 1'b1 && (Address !== a || DataOut !== d)) hold_err++;
        end
        if (Req === 1'b1) begin
          Ack = 1'b1;
          repeat (ack_hold) @(negedge Clk);
          Ack = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (Busy === 1'b1 && Req === 1'b1) req_busy++;
  end

  task automatic arm(input logic [21:0] b, input logic [21:0] l);
    @(negedge Clk);
    BaseAddr = b; CaptureLen = l; Arm = 1'b1;
    @(negedge Clk);
    Arm = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    @(negedge Clk);
    SampleData = d; SampleValid = 1'b1;
    @(negedge Clk);
    SampleValid = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < budget) begin @(negedge Clk); n++; end
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout Done=%b required 1", tag, Done); end
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n;
    n = 0;
    while (Req !== 1'b1 && n < budget) begin @(negedge Clk); n++; end
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL %s_req_timeout Req=%b required 1", tag, Req); end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten} !== RST_VEC) begin
      errors++; $display("FAIL reset_held got %h required %h",
        {Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten}, RST_VEC);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten} !== RST_VEC) begin
      errors++; $display("FAIL reset_released got %h required %h",
        {Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten}, RST_VEC);
    end
  endtask

  task automatic test_normal;
    ack_dly = 1; ack_hold = 2;
    got_addr.delete(); got_data.delete();
    @(negedge Clk);
    BaseAddr = 22'h100; CaptureLen = 22'd4; Arm = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    Arm = 1'b0; Abort = 1'b0;
    checks++;
    if (Capturing !== 1'b1) begin errors++; $display("FAIL arm_beats_abort Capturing=%b required 1", Capturing); end
    send(16'hA001, 1);
    @(negedge Clk);
    BaseAddr = 22'h999; CaptureLen = 22'd1; Arm = 1'b1;
    @(negedge Clk);
    Arm = 1'b0;
    for (int i = 1; i < 4; i++) send(16'(16'hA001 + i), 1);
    wait_done(200, "normal");
    checks++;
    if (got_addr.size() != 4) begin errors++; $display("FAIL normal_count got %0d required 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== 22'(22'h100 + i) || got_data[i] !== 16'(16'hA001 + i)) begin
        errors++; $display("FAIL normal_write[%0d] got %h/%h required %h/%h", i,
          got_addr[i], got_data[i], 22'(22'h100 + i), 16'(16'hA001 + i));
      end
    end
    checks++;
    if (WordsWritten !== 22'd4 || Overflow !== 1'b0 || WnR !== 1'b1) begin
      errors++; $display("FAIL normal_status words=%0d ovf=%b wnr=%b required 4/0/1", WordsWritten, Overflow, WnR);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || Capturing !== 1'b0) begin
      errors++; $display("FAIL done_sticky Done=%b Capturing=%b required 1/0", Done, Capturing);
    end
  endtask

  task automatic test_busy_stall;
    logic [15:0] s[20];
    int n;
    ack_dly = 1; ack_hold = 1;
    got_addr.delete(); got_data.delete();
    Busy = 1'b1; req_busy = 0;
    arm(22'h2000, 22'd20);
    for (int i = 0; i < 20; i++) begin s[i] = 16'($urandom); send(s[i], 0); end
    repeat (256) @(negedge Clk);
    checks++;
    if (Overflow !== 1'b1) begin errors++; $display("FAIL busy_overflow got %b required 1", Overflow); end
    checks++;
    if (req_busy != 0 || got_addr.size() != 0) begin
      errors++; $display("FAIL busy_no_req req_cycles=%0d writes=%0d required 0/0", req_busy, got_addr.size());
    end
    Busy = 1'b0;
    n = 0;
    while (WordsWritten !== 22'd16 && n < 300) begin @(negedge Clk); n++; end
    repeat (4) @(negedge Clk);
    checks++;
    if (WordsWritten !== 22'd16 || got_addr.size() != 16 || Done !== 1'b0) begin
      errors++; $display("FAIL busy_stored words=%0d writes=%0d done=%b required 16/16/0",
        WordsWritten, got_addr.size(), Done);
    end
    for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== 22'(22'h2000 + i) || got_data[i] !== s[i]) begin
        errors++; $display("FAIL busy_write[%0d] got %h/%h required %h/%h", i,
          got_addr[i], got_data[i], 22'(22'h2000 + i), s[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin s[i] = 16'($urandom); send(s[i], 2); end
    wait_done(200, "busy_tail");
    checks++;
    if (got_addr.size() != 20 || WordsWritten !== 22'd20 || Overflow !== 1'b1) begin
      errors++; $display("FAIL busy_tail writes=%0d words=%0d ovf=%b required 20/20/1",
        got_addr.size(), WordsWritten, Overflow);
    end
    for (int i = 0; i < 4 && 16 + i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[16+i] !== 22'(22'h2010 + i) || got_data[16+i] !== s[i]) begin
        errors++; $display("FAIL busy_tail_write[%0d] got %h/%h required %h/%h", i,
          got_addr[16+i], got_data[16+i], 22'(22'h2010 + i), s[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [21:0] ea[3];
    logic [15:0] s[3];
    ea[0] = 22'h3FFFFE; ea[1] = 22'h3FFFFF; ea[2] = 22'h000000;
    ack_dly = 2; ack_hold = 1;
    got_addr.delete(); got_data.delete();
    arm(22'h3FFFFE, 22'd3);
    for (int i = 0; i < 3; i++) begin s[i] = 16'($urandom); send(s[i], 1); end
    wait_done(200, "wrap");
    checks++;
    if (got_addr.size() != 3) begin errors++; $display("FAIL wrap_count got %0d required 3", got_addr.size()); end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== ea[i] || got_data[i] !== s[i]) begin
        errors++; $display("FAIL wrap_write[%0d] got %h/%h required %h/%h", i, got_addr[i], got_data[i], ea[i], s[i]);
      end
    end
  endtask

  task automatic test_abort;
    logic [15:0] s[3];
    logic [15:0] x;
    int n;
    ack_dly = 30; ack_hold = 1;
    got_addr.delete(); got_data.delete();
    arm(22'h40, 22'd8);
    for (int i = 0; i < 3; i++) begin s[i] = 16'($urandom); send(s[i], 0); end
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL abort_req_pending got %b required 1", Req); end
    @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL abort_req_held got %b required 1", Req); end
    n = 0;
    while (Capturing !== 1'b0 && n < 100) begin @(negedge Clk); n++; end
    repeat (3) @(negedge Clk);
    checks++;
    if (got_addr.size() != 1 || WordsWritten !== 22'd1 || Done !== 1'b0 || Capturing !== 1'b0) begin
      errors++; $display("FAIL abort_status writes=%0d words=%0d done=%b capt=%b required 1/1/0/0",
        got_addr.size(), WordsWritten, Done, Capturing);
    end
    checks++;
    if (got_addr.size() > 0 && (got_addr[0] !== 22'h40 || got_data[0] !== s[0])) begin
      errors++; $display("FAIL abort_write got %h/%h required %h/%h", got_addr[0], got_data[0], 22'h40, s[0]);
    end
    ack_dly = 1;
    got_addr.delete(); got_data.delete();
    x = 16'($urandom);
    arm(22'h80, 22'd1);
    send(x, 1);
    wait_done(100, "abort_flush");
    checks++;
    if (got_data.size() != 1 || got_data[0] !== x) begin
      errors++; $display("FAIL abort_flush writes=%0d first=%h required 1/%h",
        got_data.size(), (got_data.size() > 0) ? got_data[0] : 16'h0, x);
    end
  endtask

  task automatic test_zero_len;
    got_addr.delete(); got_data.delete();
    arm(22'h123, 22'd0);
    @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || Capturing !== 1'b0) begin
      errors++; $display("FAIL zero_done Done=%b Capturing=%b required 1/0", Done, Capturing);
    end
    send(16'($urandom), 5);
    checks++;
    if (got_addr.size() != 0 || Overflow !== 1'b0 || WordsWritten !== 22'd0) begin
      errors++; $display("FAIL zero_noop writes=%0d ovf=%b words=%0d required 0/0/0",
        got_addr.size(), Overflow, WordsWritten);
    end
  endtask

  task automatic test_random;
    logic [21:0] base;
    logic [21:0] len;
    logic [15:0] q[$];
    for (int it = 0; it < 5; it++) begin
      base = 22'($urandom);
      if (it == 0) base = 22'h3FFFFA;
      len = 22'($urandom_range(1, 12));
      ack_dly = $urandom_range(1, 4);
      ack_hold = $urandom_range(1, 3);
      q.delete(); got_addr.delete(); got_data.delete();
      arm(base, len);
      checks++;
      if (Done !== 1'b0) begin errors++; $display("FAIL rand%0d_done_cleared got %b required 0", it, Done); end
      for (int i = 0; i < int'(len) + 2; i++) begin
        q.push_back(16'($urandom));
        send(q[i], $urandom_range(8, 12));
      end
      wait_done(400, "rand");
      checks++;
      if (got_addr.size() != int'(len) || WordsWritten !== len || Overflow !== 1'b0) begin
        errors++; $display("FAIL rand%0d_status writes=%0d words=%0d ovf=%b required %0d/%0d/0",
          it, got_addr.size(), WordsWritten, Overflow, len, len);
      end
      for (int i = 0; i < int'(len) && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== 22'(base + 22'(i)) || got_data[i] !== q[i]) begin
          errors++; $display("FAIL rand%0d_write[%0d] got %h/%h required %h/%h", it, i,
            got_addr[i], got_data[i], 22'(base + 22'(i)), q[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    ack_dly = 40; ack_hold = 1;
    got_addr.delete(); got_data.delete();
    arm(22'h55, 22'd2);
    send(16'($urandom), 0);
    wait_req(20, "async");
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL async_req_drop got %b required 0", Req); end
    checks++;
    if ({Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten} !== RST_VEC) begin
      errors++; $display("FAIL async_outputs got %h required %h",
        {Req, WnR, Address, DataOut, Capturing, Done, Overflow, WordsWritten}, RST_VEC);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (Req !== 1'b0 || Ack !== 1'b0 || Capturing !== 1'b0) begin
      errors++; $display("FAIL async_after Req=%b Ack=%b Capturing=%b required 0/0/0", Req, Ack, Capturing);
    end
  endtask

  initial begin
    Reset_n = 1'b0; SampleValid = 1'b0; SampleData = '0; Arm = 1'b0; Abort = 1'b0;
    Busy = 1'b0; BaseAddr = '0; CaptureLen = '0;
    test_reset();
    test_normal();
    test_busy_stall();
    test_wrap();
    test_abort();
    test_zero_len();
    test_random();
    test_async_reset();
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL req_hold_stable got %0d changes required 0", hold_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_writer.md
ADC_CAPTURE_WRITER -- requirements
Module: adc_capture_writer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 16, sample and SDRAM word width.
- ADDR_W, 22, SDRAM word address width.
- FIFO_AW, 4, FIFO address bits (depth 16).

REQ-002 Ports, one per line: name, direction, width, meaning.
- Clk, in, 1, single clock; all logic on the rising edge.
- Reset_n, in, 1, asynchronous active-low reset.
- SampleData, in, DATA_W, ADC sample word.
- SampleValid, in, 1, one-cycle sample strobe.
- Arm, in, 1, start-capture pulse.
- Abort, in, 1, stop-capture pulse.
- BaseAddr, in, ADDR_W, first SDRAM word address; sampled at Arm.
- CaptureLen, in, ADDR_W, words to store; sampled at Arm; 0 is a complete no-op capture.
- Req, out, 1, request to the SDRAM interface.
- WnR, out, 1, write-not-read; always 1.
- Address, out, ADDR_W, SDRAM word address.
- DataOut, out, DATA_W, word to write.
- Busy, in, 1, SDRAM interface busy (refresh, init, access).
- Ack, in, 1, SDRAM request acknowledge; may stay high for more than one cycle.
- Capturing, out, 1, capture in progress.
- Done, out, 1, sticky: capture completed; cleared by Arm.
- Overflow, out, 1, sticky: a sample was dropped; cleared by Arm.
- WordsWritten, out, ADDR_W, count of acknowledged writes.

Function
REQ-003 Every SampleValid in CAPTURE while fewer than CaptureLen samples are accepted SHALL push SampleData into the FIFO.
REQ-004 A SampleValid arriving while the FIFO is full SHALL drop the sample and set Overflow; the accepted-sample count SHALL NOT increment.
REQ-005 SampleValid outside CAPTURE, or after CaptureLen samples are accepted, SHALL be ignored without setting a flag.
REQ-006 The state machine states SHALL be IDLE, CAPTURE, ISSUE, WAIT_ACK, DRAIN and DONE.
REQ-007 IDLE: Arm SHALL latch BaseAddr and CaptureLen, clear Done, Overflow and WordsWritten, flush the FIFO, and go to CAPTURE; if CaptureLen==0 it SHALL go to DONE instead.
REQ-008 CAPTURE: when the FIFO is non-empty, Busy==0 and Ack==0, the block SHALL go to ISSUE.
REQ-009 ISSUE: Req SHALL be 1, with Address = BaseAddr + WordsWritten and DataOut = FIFO head, all registered and held stable; the block SHALL go to WAIT_ACK.
REQ-010 WAIT_ACK: Req, Address and DataOut SHALL be held until Ack==1.
REQ-011 On the cycle Ack==1 is sampled, the block SHALL deassert Req, pop the FIFO and increment WordsWritten.
REQ-012 After REQ-011, if WordsWritten reaches CaptureLen the block SHALL go to DONE, otherwise to CAPTURE.
REQ-013 A new request SHALL NOT be issued until Ack has returned to 0 and Busy==0.
REQ-014 Address arithmetic SHALL be modulo 2^ADDR_W (wraps from 0x3FFFFF to 0x000000).
REQ-015 Abort in CAPTURE SHALL go to DRAIN; Abort in ISSUE or WAIT_ACK SHALL let the outstanding write complete, then go to DRAIN.
REQ-016 DRAIN: the block SHALL flush the FIFO and go to IDLE, with Done left 0.
REQ-017 DONE: Done SHALL be 1 and the block SHALL go to IDLE on the next cycle; Done SHALL remain set in IDLE until the next Arm.
REQ-018 Arm outside IDLE SHALL be ignored.
REQ-019 If Abort and Arm arrive in the same cycle in IDLE, Arm SHALL win.
REQ-020 Capturing SHALL be 1 in CAPTURE, ISSUE and WAIT_ACK, and 0 elsewhere.
REQ-021 Simultaneous FIFO push and pop SHALL be legal when the FIFO is full, and SHALL NOT set Overflow.

Reset
REQ-022 Reset_n==0 SHALL asynchronously force: state IDLE, FIFO empty, Req=0, WnR=1, Address=0, DataOut=0, Capturing=0, Done=0, Overflow=0, WordsWritten=0.
REQ-023 Reset in mid-transaction SHALL drop Req immediately with no completion tracking; the SDRAM interface is reset by the same system reset.

Structure
REQ-024 The state encoding and the DATA_W and ADDR_W defaults SHALL reside in the shared package adc_sdram_pkg.
REQ-025 The FIFO SHALL be the sub-module sample_fifo (synchronous, first-word-fall-through, full/empty flags, DATA_W x 2^FIFO_AW).

Verification
REQ-026 Directed scenarios the bench SHALL cover:
- Normal capture: Arm with BaseAddr=0x100, CaptureLen=4, then 4 samples 0xA001..0xA004 with Busy=0 and a 2-cycle Ack -> writes to 0x100..0x103 in order, WordsWritten=4, Done=1, Overflow=0.
- Busy stall: Busy=1 for 300 cycles while 20 samples arrive -> 16 stored, Overflow=1, no Req while Busy=1, first 16 samples written in order.
- Address wrap: BaseAddr=0x3FFFFE, CaptureLen=3 -> write addresses 0x3FFFFE, 0x3FFFFF, 0x000000.
- Abort mid-write: Abort during WAIT_ACK -> Req held until Ack, that write counted, FIFO flushed, Done=0, state IDLE.
- Zero length: Arm with CaptureLen=0 -> no Req issued, Done=1 within 2 cycles.
- Async reset: Reset_n low during ISSUE -> Req=0 immediately, all outputs at reset values.
